// File: rtl/exu_fpu_issue_ctl.sv
`default_nettype none
// ============================================================================
// Module      : exu_fpu_issue_ctl
// Description : Single-issue scheduler between decode and the pipelined FPU.
//               It takes at most one op per cycle from decode slot i0 or i1.
//               RAW and WAW hazards are checked against a 32-entry FP
//               register scoreboard. The single writeback port is protected
//               by a latency-slot reservation ring. Each issued op produces
//               a writeback strobe exactly L cycles after issue.
//
// Packet layouts (flat vectors):
//   *_pkt  [PKT_W-1:0] : [0] valid (ignored on input), [1] fma, [2] mv,
//                        [PKT_W-1:3] opaque op fields passed through
//   *_regs [19:0]      : {rd[19:15], rs3[14:10], rs2[9:5], rs1[4:0]}
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   iN_valid/pkt/regs        decode slot N operation
//   iN_src_fp [2:0]          {rs3,rs2,rs1} read FP regs (scoreboard-checked)
//   iN_rd_fp                 destination is an FP register
//   iN_ready                 slot N op issues this cycle
//   flush                    kill all in-flight work
//   issue_valid/pkt/slot     launched op, its packet and latency
//   wb_valid/rd/rd_fp        registered writeback strobe
//   sb_busy [31:0]           registered scoreboard
//   fpu_busy                 any op in flight
//
// Revision    : 1.0  initial release
// ============================================================================
module exu_fpu_issue_ctl #(
    parameter int FMA_LAT   = 4,
    parameter int ARITH_LAT = 3,
    parameter int MV_LAT    = 1,
    parameter int PKT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i0_valid,
    input  logic [PKT_W-1:0] i0_pkt,
    input  logic [19:0]      i0_regs,
    input  logic [2:0]       i0_src_fp,
    input  logic             i0_rd_fp,
    output logic             i0_ready,
    input  logic             i1_valid,
    input  logic [PKT_W-1:0] i1_pkt,
    input  logic [19:0]      i1_regs,
    input  logic [2:0]       i1_src_fp,
    input  logic             i1_rd_fp,
    output logic             i1_ready,
    input  logic             flush,
    output logic             issue_valid,
    output logic [PKT_W-1:0] issue_pkt,
    output logic [2:0]       issue_slot,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic             wb_rd_fp,
    output logic [31:0]      sb_busy,
    output logic             fpu_busy
);

    localparam logic [2:0] c_FMA_LAT   = 3'(FMA_LAT);
    localparam logic [2:0] c_ARITH_LAT = 3'(ARITH_LAT);
    localparam logic [2:0] c_MV_LAT    = 3'(MV_LAT);

    if (FMA_LAT < 1 || FMA_LAT > 7 || ARITH_LAT < 1 || ARITH_LAT > 7 ||
        MV_LAT < 1 || MV_LAT > 7) begin : g_lat_check
        $error("exu_fpu_issue_ctl: latencies must be in 1..7");
    end

    // Reservation ring, slots 1..7. An op in registered slot k writes back
    // k cycles later. Slot 7 is never occupied in registered state (a
    // latency-7 op lands in slot 6 after the same-edge shift) but is kept so
    // the structural check indexes uniformly by latency.
    logic [7:1] r_ring_v;
    logic [7:1] r_ring_fp;
    logic [4:0] r_ring_rd [1:7];

    logic [7:1] w_ring_v;
    logic [7:1] w_ring_fp;
    logic [4:0] w_ring_rd [1:7];

    logic             w_sel_i1;
    logic             w_cand;
    logic [PKT_W-1:0] w_pkt;
    logic [19:0]      w_regs;
    logic [2:0]       w_src_fp;
    logic             w_rd_fp;
    logic [4:0]       w_rs1, w_rs2, w_rs3, w_rd;
    logic [2:0]       w_lat;
    logic             w_raw, w_waw, w_struct;
    logic             w_issue;
    logic [31:0]      w_sb_set, w_sb_clr;
    logic             w_unused_ok;

    // i1 is only considered when i0 is empty; it never bypasses a stalled i0.
    assign w_sel_i1 = ~i0_valid & i1_valid;
    assign w_cand   = i0_valid | i1_valid;
    assign w_pkt    = w_sel_i1 ? i1_pkt    : i0_pkt;
    assign w_regs   = w_sel_i1 ? i1_regs   : i0_regs;
    assign w_src_fp = w_sel_i1 ? i1_src_fp : i0_src_fp;
    assign w_rd_fp  = w_sel_i1 ? i1_rd_fp  : i0_rd_fp;

    assign w_rs1 = w_regs[4:0];
    assign w_rs2 = w_regs[9:5];
    assign w_rs3 = w_regs[14:10];
    assign w_rd  = w_regs[19:15];

    assign w_lat = w_pkt[1] ? c_FMA_LAT : (w_pkt[2] ? c_MV_LAT : c_ARITH_LAT);

    // Hazards look only at registered state, keeping ready off the wb path.
    assign w_raw    = (w_src_fp[0] & sb_busy[w_rs1]) |
                      (w_src_fp[1] & sb_busy[w_rs2]) |
                      (w_src_fp[2] & sb_busy[w_rs3]);
    assign w_waw    = w_rd_fp & sb_busy[w_rd];
    assign w_struct = r_ring_v[w_lat];

    assign w_issue  = w_cand & ~w_raw & ~w_waw & ~w_struct & ~flush & ~rst;

    assign issue_valid = w_issue;
    assign issue_pkt   = {w_pkt[PKT_W-1:1], w_issue};
    assign issue_slot  = w_lat;
    assign i0_ready    = w_issue & ~w_sel_i1;
    assign i1_ready    = w_issue &  w_sel_i1;

    assign w_unused_ok = w_pkt[0];

    // Insert the issuing op at slot L; the shift at the edge then moves it
    // to slot L-1 (or straight into wb_* for L=1), giving wb at t+L.
    always_comb begin
        w_ring_v  = r_ring_v;
        w_ring_fp = r_ring_fp;
        w_ring_rd = r_ring_rd;
        if (w_issue) begin
            w_ring_v[w_lat]  = 1'b1;
            w_ring_fp[w_lat] = w_rd_fp;
            w_ring_rd[w_lat] = w_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_ring_v  <= '0;
            r_ring_fp <= '0;
            for (int k = 1; k <= 7; k++) begin
                r_ring_rd[k] <= '0;
            end
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_rd_fp <= 1'b0;
        end else begin
            wb_valid <= w_ring_v[1];
            wb_rd    <= w_ring_rd[1];
            wb_rd_fp <= w_ring_fp[1];
            for (int k = 1; k <= 6; k++) begin
                r_ring_v[k]  <= w_ring_v[k+1];
                r_ring_fp[k] <= w_ring_fp[k+1];
                r_ring_rd[k] <= w_ring_rd[k+1];
            end
            r_ring_v[7]  <= 1'b0;
            r_ring_fp[7] <= 1'b0;
            r_ring_rd[7] <= '0;
        end
    end

    // Same-rd set and clear cannot coincide: WAW holds the bit set through
    // the writeback cycle.
    assign w_sb_set = (w_issue  & w_rd_fp)  ? (32'd1 << w_rd)  : 32'd0;
    assign w_sb_clr = (wb_valid & wb_rd_fp) ? (32'd1 << wb_rd) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            sb_busy <= '0;
        end else begin
            sb_busy <= (sb_busy & ~w_sb_clr) | w_sb_set;
        end
    end

    assign fpu_busy = (|r_ring_v) | wb_valid;

endmodule
`default_nettype wire
